// File: rtl/barrel_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : barrel_pkg
//  Description : Shared constants and helpers for the barrel shift/multiply
//                datapath library (left-shift multiplier, right-shift divider).
//                  c_default_width   : default operand width
//                  c_default_shift_w : default shift-amount width
//                  sat_value()       : saturation pattern for a given sign
//  Revision    : 1.0  initial release
// ============================================================================
package barrel_pkg;

   localparam int c_default_width   = 8;
   localparam int c_default_shift_w = 3;

   // Widest operand sat_value() can describe; callers truncate to their width.
   localparam int c_sat_max_w       = 64;

   // Two's complement clamp value: sign=1 -> most negative, sign=0 -> most
   // positive.  Bits at or above 'width' are zero.
   function automatic logic [c_sat_max_w-1:0] sat_value(input logic sign,
                                                        input int   width);
      logic [c_sat_max_w-1:0] sat;
      sat = '0;
      for (int i = 0; i < c_sat_max_w; i++) begin
         if (i < width) begin
            sat[i] = (i == width - 1) ? sign : ~sign;
         end
      end
      return sat;
   endfunction

endpackage
`default_nettype wire

// File: rtl/barrel_shl_stage.sv
`default_nettype none
// ============================================================================
//  Module      : barrel_shl_stage
//  Description : One registered stage of the logarithmic left shifter.
//                Shifts left by AMT (zero fill) when its shift bit is set,
//                accumulates signed overflow, and applies valid/ready
//                handshaking with a one-entry register.
//  Ports       : clk, rst                 clock, async active-high reset
//                prev_valid/data/shift/
//                sign/ovf                 item from the upstream stage
//                next_ready               downstream stage can take an item
//                valid/data/shift/sign/ovf  registered item of this stage
//  Revision    : 1.0  initial release
// ============================================================================
module barrel_shl_stage
   import barrel_pkg::*;
#(
   parameter int WIDTH   = c_default_width,
   parameter int SHIFT_W = c_default_shift_w,
   parameter int AMT     = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               prev_valid,
   input  logic [WIDTH-1:0]   prev_data,
   input  logic [SHIFT_W-1:0] prev_shift,
   input  logic               prev_sign,
   input  logic               prev_ovf,
   input  logic               next_ready,
   output logic               valid,
   output logic [WIDTH-1:0]   data,
   output logic [SHIFT_W-1:0] shift,
   output logic               sign,
   output logic               ovf
);

   // AMT is always a power of two; this is the shift bit it serves.
   localparam int BIT = $clog2(AMT);

   logic               r_valid;
   logic [WIDTH-1:0]   r_data;
   logic [SHIFT_W-1:0] r_shift;
   logic               r_sign;
   logic               r_ovf;

   logic               w_ready;
   logic [WIDTH-1:0]   w_shifted;
   logic               w_lost;

   assign w_ready = ~r_valid | next_ready;

   // The item stays representable only if the AMT bits shifted out and the
   // new MSB all equal the original sign, i.e. the top AMT+1 bits are sign.
   generate
      if (AMT < WIDTH) begin : g_partial
         assign w_shifted = prev_data << AMT;
         assign w_lost    = (prev_data[WIDTH-1 -: AMT+1] != {(AMT+1){prev_sign}});
      end else begin : g_full
         // Everything leaves the word and the new MSB is a zero fill bit.
         assign w_shifted = '0;
         assign w_lost    = (prev_data != {WIDTH{prev_sign}}) | prev_sign;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_shift <= '0;
         r_sign  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_ready) begin
         r_valid <= prev_valid;
         if (prev_valid) begin
            r_shift <= prev_shift;
            r_sign  <= prev_sign;
            if (prev_shift[BIT]) begin
               r_data <= w_shifted;
               r_ovf  <= prev_ovf | w_lost;
            end else begin
               r_data <= prev_data;
               r_ovf  <= prev_ovf;
            end
         end
      end
   end

   assign valid = r_valid;
   assign data  = r_data;
   assign shift = r_shift;
   assign sign  = r_sign;
   assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: rtl/barrel_multiplier_u2.sv
`default_nettype none
// ============================================================================
//  Module      : barrel_multiplier_u2
//  Description : Signed multiply by 2^shift_n (arithmetic left shift) built
//                as a SHIFT_W-deep logarithmic shifter, one register per
//                shift bit, with per-item overflow and optional saturation.
//  Ports       : clk        rising-edge clock
//                rst        asynchronous active-high reset
//                in_valid   operand valid
//                in_ready   operand accepted when in_valid & in_ready
//                in         signed operand
//                shift_n    left-shift amount, travels with the operand
//                out_valid  result valid
//                out_ready  result consumed when out_valid & out_ready
//                out        signed result (saturated or wrapped)
//                ovf        overflow flag for the item on out
//  Revision    : 1.0  initial release
// ============================================================================
module barrel_multiplier_u2
   import barrel_pkg::*;
#(
   parameter int WIDTH    = c_default_width,
   parameter int SHIFT_W  = c_default_shift_w,
   parameter int SATURATE = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in,
   input  logic [SHIFT_W-1:0] shift_n,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out,
   output logic               ovf
);

   // Index 0 is the input port; index k+1 is the register of stage k.
   logic [SHIFT_W:0]   w_valid;
   logic [SHIFT_W:0]   w_sign;
   logic [SHIFT_W:0]   w_ovf;
   logic [WIDTH-1:0]   w_data  [0:SHIFT_W];
   logic [SHIFT_W-1:0] w_shift [0:SHIFT_W];

   logic [WIDTH-1:0]   w_sat;
   logic               w_unused_shift;

   assign w_valid[0] = in_valid;
   assign w_data[0]  = in;
   assign w_shift[0] = shift_n;
   assign w_sign[0]  = in[WIDTH-1];
   assign w_ovf[0]   = 1'b0;

   // The ready chain ready_k = ~valid_k | ready_{k+1} unrolls to: a stage
   // can move if the output is ready or any later stage holds a bubble.
   // Written in closed form so it depends only on registered valids.
   assign in_ready = out_ready | ~(&w_valid[SHIFT_W:1]);

   generate
      for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
         logic w_next_ready;

         if (k == SHIFT_W - 1) begin : g_last
            assign w_next_ready = out_ready;
         end else begin : g_mid
            assign w_next_ready = out_ready | ~(&w_valid[SHIFT_W:k+2]);
         end

         barrel_shl_stage #(
            .WIDTH   (WIDTH),
            .SHIFT_W (SHIFT_W),
            .AMT     (2**k)
         ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .prev_valid (w_valid[k]),
            .prev_data  (w_data[k]),
            .prev_shift (w_shift[k]),
            .prev_sign  (w_sign[k]),
            .prev_ovf   (w_ovf[k]),
            .next_ready (w_next_ready),
            .valid      (w_valid[k+1]),
            .data       (w_data[k+1]),
            .shift      (w_shift[k+1]),
            .sign       (w_sign[k+1]),
            .ovf        (w_ovf[k+1])
         );
      end
   endgenerate

   // All shift bits are consumed by the time an item leaves the last stage.
   assign w_unused_shift = ^w_shift[SHIFT_W];

   assign w_sat     = WIDTH'(sat_value(w_sign[SHIFT_W], WIDTH));
   assign out_valid = w_valid[SHIFT_W];
   assign ovf       = w_ovf[SHIFT_W];
   assign out       = ((SATURATE != 0) && w_ovf[SHIFT_W]) ? w_sat : w_data[SHIFT_W];

endmodule
`default_nettype wire

// File: tb/tb_barrel_multiplier_u2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_barrel_multiplier_u2
//  Description : Self-checking bench for barrel_multiplier_u2.  Two DUT
//                copies (saturating and wrapping) share one stimulus stream;
//                results are compared with an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_barrel_multiplier_u2;

   localparam int WIDTH   = 8;
   localparam int SHIFT_W = 3;
   localparam int LAT     = SHIFT_W;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   in_data;
   logic [SHIFT_W-1:0] shift_n;

   logic               in_ready;
   logic               out_valid;
   logic               ovf;
   logic [WIDTH-1:0]   out_sat;

   logic               in_ready_unused;
   logic               out_valid_w;
   logic               ovf_w;
   logic [WIDTH-1:0]   out_wrap;

   always #5 clk = ~clk;

   barrel_multiplier_u2 #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W), .SATURATE(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (in_data),
      .shift_n   (shift_n),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out_sat),
      .ovf       (ovf)
   );

   barrel_multiplier_u2 #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W), .SATURATE(0)) dut_wrap (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_unused),
      .in        (in_data),
      .shift_n   (shift_n),
      .out_valid (out_valid_w),
      .out_ready (out_ready),
      .out       (out_wrap),
      .ovf       (ovf_w)
   );

   typedef struct {
      logic [WIDTH-1:0] sat;
      logic [WIDTH-1:0] wrap;
      logic             ovf;
      int               acc;
      bit               lat;
   } item_t;

   item_t exp_q[$];
   int    out_cyc[$];
   int    n_checks = 0;
   int    n_errors = 0;
   int    cyc      = 0;
   bit    chk_lat  = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference: exact integer product, overflow = outside the signed range.
   function automatic item_t model(input logic [WIDTH-1:0] a, input logic [SHIFT_W-1:0] s);
      item_t  it;
      longint p;
      longint hi;
      longint lo;
      hi      = (longint'(1) << (WIDTH - 1)) - 1;
      lo      = -hi - 1;
      p       = longint'($signed(a)) * (longint'(1) << s);
      it.ovf  = (p > hi) || (p < lo);
      it.wrap = p[WIDTH-1:0];
      if (it.ovf) it.sat = (p < 0) ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else        it.sat = it.wrap;
      it.acc  = 0;
      it.lat  = 1'b0;
      return it;
   endfunction

   // Monitor: looks at handshakes just after the falling edge, i.e. the
   // values that the next rising edge will act on.
   always @(negedge clk) begin
      #1;
      cyc++;
      if (!rst) begin
         if (in_valid && in_ready) begin
            item_t it;
            it     = model(in_data, shift_n);
            it.acc = cyc;
            it.lat = chk_lat;
            exp_q.push_back(it);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_val("spurious_out", 32'(out_valid), 32'd0);
            end else begin
               item_t e;
               e = exp_q.pop_front();
               check_val("out_sat",    32'(out_sat),     32'(e.sat));
               check_val("ovf_sat",    32'(ovf),         32'(e.ovf));
               check_val("wrap_valid", 32'(out_valid_w), 32'd1);
               check_val("out_wrap",   32'(out_wrap),    32'(e.wrap));
               check_val("ovf_wrap",   32'(ovf_w),       32'(e.ovf));
               if (e.lat) check_val("latency", 32'(cyc - e.acc), 32'(LAT));
               out_cyc.push_back(cyc);
            end
         end
      end
   end

   // In-flight items vanish the moment reset is applied.
   always @(posedge rst) exp_q.delete();

   // Call on a falling edge; returns on the falling edge after acceptance.
   task automatic send(input logic [WIDTH-1:0] a, input logic [SHIFT_W-1:0] s);
      int guard;
      guard    = 0;
      in_data  = a;
      shift_n  = s;
      in_valid = 1'b1;
      #1;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (!in_ready) check_val("send_timeout", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard     = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || out_valid) && guard < 200) begin
         @(negedge clk);
         #2;
         guard++;
      end
      check_val("drain_empty", 32'(exp_q.size()), 32'd0);
      check_val("drain_idle",  32'(out_valid),    32'd0);
      @(negedge clk);
   endtask

   logic [WIDTH-1:0]   dir_a [11] = '{8'h05, 8'hFD, 8'h20, 8'h80, 8'h5A, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h7F, 8'hC0};
   logic [SHIFT_W-1:0] dir_s [11] = '{3'd3,  3'd2,  3'd2,  3'd1,  3'd0,  3'd7,  3'd7,  3'd0,  3'd7,  3'd1,  3'd1};

   initial begin
      int               acc;
      bit               acc_prev;
      logic [WIDTH-1:0] nxt;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_data   = '0;
      shift_n   = '0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_out",       32'(out_sat),   32'd0);
      check_val("rst_ovf",       32'(ovf),       32'd0);
      check_val("rst_out_wrap",  32'(out_wrap),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);

      // Directed operands, back to back, no backpressure
      chk_lat = 1'b1;
      for (int i = 0; i < 11; i++) send(dir_a[i], dir_s[i]);
      drain();

      // Streaming 0x01..0x10 by 2: one result per cycle after the latency
      out_cyc.delete();
      for (int i = 1; i <= 16; i++) send(WIDTH'(i), 3'd1);
      drain();
      check_val("stream_count", 32'(out_cyc.size()), 32'd16);
      if (out_cyc.size() == 16) check_val("stream_gapless", 32'(out_cyc[15] - out_cyc[0]), 32'd15);

      // Backpressure: pipeline holds exactly SHIFT_W items
      chk_lat   = 1'b0;
      out_ready = 1'b0;
      acc       = 0;
      nxt       = 8'h11;
      for (int i = 0; i < 6; i++) begin
         in_data  = nxt;
         shift_n  = 3'd2;
         in_valid = 1'b1;
         #1;
         if (in_ready) begin
            acc++;
            nxt = nxt + 8'h11;
         end
         @(negedge clk);
      end
      #1;
      check_val("bp_accepted", 32'(acc),      32'(SHIFT_W));
      check_val("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      drain();

      // Reset with two items in flight
      chk_lat = 1'b1;
      send(8'h03, 3'd1);
      send(8'h04, 3'd1);
      #2;
      rst = 1'b1;
      #1;
      check_val("midrst_out_valid",   32'(out_valid),   32'd0);
      check_val("midrst_out_valid_w", 32'(out_valid_w), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) begin
         @(negedge clk);
         #1;
         check_val("post_rst_idle", 32'(out_valid), 32'd0);
      end
      @(negedge clk);
      send(8'h09, 3'd2);
      drain();

      // Randomized traffic with random stalls on both sides
      chk_lat  = 1'b0;
      acc_prev = 1'b0;
      in_valid = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!in_valid || acc_prev) begin
            in_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
               0:       in_data = '0;
               1:       in_data = '1;
               2:       in_data = {1'b1, {(WIDTH-1){1'b0}}};
               default: in_data = WIDTH'($urandom);
            endcase
            shift_n = SHIFT_W'($urandom);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         acc_prev = in_valid && in_ready;
         @(negedge clk);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
`default_nettype wire
